ram_pipe: RTL and testbench
===========================

// Module: ram_pipe
// PURPOSE
//  Parametrised single-port data RAM with req/addr_ok/data_ok handshake, byte write mask,
//  configurable read latency, in-order multi-outstanding requests and consumer backpressure.
//  Replaces the fixed-size, fixed-latency core RAM wrapper; sits behind the LSU/IFU memory
//  interface and serves as the behavioural model for core and SoC simulation.
// PARAMETERS
//  DW           32    data width, bits; multiple of 8
//  AW           32    byte address width
//  DEPTH        512   words; power of 2
//  MW           DW/8  byte-mask width
//  LATENCY      1     accept edge -> earliest data_ok, cycles; >=1
//  OUTSTANDING  2     max accepted-but-not-consumed responses; >=1
//  FORCE_X2ZERO 0     1: X bits on datao driven as 0 (sim only)
// PORTS
//  clk            in   1    clock, rising edge
//  rst            in   1    asynchronous reset, active-high
//  mem_req        in   1    request valid
//  we             in   1    1 = write, 0 = read
//  addr           in   AW   byte address
//  datai          in   DW   write data
//  wem            in   MW   write byte enables, bit i -> datai[8i+7:8i]
//  mem_addr_ok    out  1    request accepted this cycle when mem_req && mem_addr_ok
//  datao          out  DW   response data (read data; 0 for write responses)
//  mem_data_ok    out  1    response valid
//  mem_data_ready in   1    consumer takes response when mem_data_ok && mem_data_ready
// BEHAVIOUR
//  - Reset (async, rst=1): mem_addr_ok=0 while rst high, mem_data_ok=0, datao=0; pipeline valids,
//    FIFO pointers, credit counter cleared. Array contents NOT reset.
//  - Indexing: word = addr[log2(DEPTH)+1:2]; addr[1:0] and upper bits ignored (wraps modulo DEPTH).
//  - Credit counter cnt (0..OUTSTANDING) = responses in pipeline + FIFO.
//    mem_addr_ok = (cnt < OUTSTANDING) || pop_this_cycle; combinational, never depends on mem_req.
//    accept&&!pop: cnt+1; pop&&!accept: cnt-1; both: unchanged.
//  - Write: bytes with wem=1 updated at accept edge; wem=0 -> no change but still one response.
//  - Read: array sampled at accept edge; a read accepted the cycle after a write to the same word
//    returns the new data. One request per cycle, so no same-cycle R/W hazard.
//  - Every accepted request yields exactly one response, strictly in acceptance order.
//  - Latency: with empty queue and mem_data_ready=1, accept at edge E -> mem_data_ok high in the
//    cycle after edge E+LATENCY-1 (LATENCY=1: next cycle). LATENCY-stage valid/data shift register
//    feeds a first-word-fall-through response FIFO (depth OUTSTANDING) with bypass when empty.
//  - Backpressure: mem_data_ok && !mem_data_ready holds datao/mem_data_ok stable; later responses
//    queue; credits stop new accepts, so FIFO never overflows and pipeline never stalls.
//  - Full throughput (1 req/cycle) sustained when OUTSTANDING >= LATENCY+1 and ready held high.
//  - Reset mid-operation: in-flight and queued responses discarded; none emerge after reset;
//    writes accepted before reset remain in the array.
//  - FORCE_X2ZERO=1: per-bit X/Z on datao replaced by 0 (uninitialised reads return 0).
// STRUCTURE
//  - Widths from shared include.v macros (`DATA_WIDTH, `BUS_WIDTH, `RAM_MASK_WIDTH) as defaults;
//    clog2 helper and response struct width constants go in the shared include.
//  - One sub-module: ram_resp_fifo (FWFT, parametrised width/depth, bypass when empty).
//  - Top holds array, byte-mask write loop, latency shift register, credit counter.
// TESTING
//  1. Defaults: write 0xDEADBEEF @0x10 wem=4'hF, then read @0x10 -> data_ok next cycle after
//     read accept, datao=0xDEADBEEF; write response datao=0.
//  2. Mask: write 0x11223344 wem=4'b0101 over 0xFFFFFFFF @0x20 -> read returns 0xFF22FF44.
//  3. LATENCY=3, OUTSTANDING=4, ready=1: 8 back-to-back reads @0x0..0x1C -> addr_ok never drops,
//     data_ok first 3 cycles after first accept, 8 responses consecutive, in order.
//  4. OUTSTANDING=2, ready=0: 3 reads -> 2 accepted, addr_ok=0 on 3rd; raise ready -> datao stable
//     until pop, pop frees credit, 3rd accepted same cycle as pop.
//  5. DEPTH=512: write 0xA5A5A5A5 @0x800 -> read @0x000 returns 0xA5A5A5A5 (wrap).
//  6. Async rst pulse mid-cycle with 2 reads in flight -> data_ok=0 immediately, no stale response
//     afterwards; earlier write still readable.

Source files
------------

// File: rtl/ram_pipe_pkg.sv
// Shared widths and helpers for the pipelined data RAM and its response FIFO.
package ram_pipe_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BUS_WIDTH      = 32;
  localparam int RAM_MASK_WIDTH = DATA_WIDTH / 8;

  // Ceiling log2, usable in parameter expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// First-word-fall-through response FIFO; an input arriving while empty is
// presented combinationally and only stored if the consumer does not take it.
module ram_resp_fifo
  import ram_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             empty, pop, push, pop_mem;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && !(empty && out_ready);
  assign pop_mem   = pop && !empty;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= next_ptr(wr_ptr);
      if (pop_mem) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop_mem)      count <= count + CW'(1);
      else if (!push && pop_mem) count <= count - CW'(1);
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which
  // entries are live, so the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/ram_pipe.sv
// Single-port data RAM with req/addr_ok/data_ok handshake, byte write mask,
// configurable read latency and credit-limited in-order outstanding responses.
module ram_pipe
  import ram_pipe_pkg::*;
#(
  parameter int DW           = DATA_WIDTH,
  parameter int AW           = BUS_WIDTH,
  parameter int DEPTH        = 512,
  parameter int MW           = DW / 8,
  parameter int LATENCY      = 1,
  parameter int OUTSTANDING  = 2,
  parameter int FORCE_X2ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] datai,
  input  logic [MW-1:0] wem,
  output logic          mem_addr_ok,
  output logic [DW-1:0] datao,
  output logic          mem_data_ok,
  input  logic          mem_data_ready
);

  localparam int IW = clog2(DEPTH);
  localparam int CW = clog2(OUTSTANDING + 1);

  logic [DW-1:0]      mem [DEPTH];
  logic [IW-1:0]      word_idx;
  logic               accept, pop;
  logic [CW-1:0]      cnt;
  logic [LATENCY-1:0] vld;
  logic [DW-1:0]      dat [LATENCY];
  logic [DW-1:0]      fifo_data, raw_data;
  logic               unused_addr;

  // Byte offset and bits above the array wrap are ignored.
  assign word_idx    = addr[IW+1:2];
  assign unused_addr = ^addr;

  assign pop         = mem_data_ok && mem_data_ready;
  assign mem_addr_ok = !rst && ((cnt < CW'(OUTSTANDING)) || pop);
  assign accept      = mem_req && mem_addr_ok;

  // Credits cover the latency pipe plus the FIFO, so neither can overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !accept) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Written bytes persist across reset.
  always_ff @(posedge clk) begin
    if (accept && we) begin
      for (int b = 0; b < MW; b++) begin
        if (wem[b]) mem[word_idx][8*b +: 8] <= datai[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= accept;
      for (int k = 1; k < LATENCY; k++) vld[k] <= vld[k-1];
    end
  end

  // Read data is captured at the accept edge; write responses carry zero.
  always_ff @(posedge clk) begin
    if (accept) dat[0] <= we ? '0 : mem[word_idx];
    for (int k = 1; k < LATENCY; k++) dat[k] <= dat[k-1];
  end

  ram_resp_fifo #(
    .WIDTH (DW),
    .DEPTH (OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld[LATENCY-1]),
    .in_data   (dat[LATENCY-1]),
    .out_valid (mem_data_ok),
    .out_data  (fifo_data),
    .out_ready (mem_data_ready)
  );

  assign raw_data = mem_data_ok ? fifo_data : '0;

  generate
    if (FORCE_X2ZERO != 0) begin : g_x2zero
      // NOTE: every bit is assigned on every evaluation, so no latch forms.
      always_comb begin
        for (int i = 0; i < DW; i++) datao[i] = (raw_data[i] === 1'b1);
      end
    end else begin : g_pass
      assign datao = raw_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_pipe.sv
// Drives two ram_pipe configurations with shared stimulus and checks both
// against a transaction-level model every cycle, plus directed literal cases.
module tb_ram_pipe;

  localparam int LAT0 = 1, OUT0 = 2;
  localparam int LAT1 = 3, OUT1 = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_req, we, mem_data_ready;
  logic [31:0]      addr, datai;
  logic [3:0]       wem;
  logic [1:0]       aok, dok;
  logic [1:0][31:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_pipe #(.LATENCY(LAT0), .OUTSTANDING(OUT0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .we(we), .addr(addr),
    .datai(datai), .wem(wem), .mem_addr_ok(aok[0]), .datao(dout[0]),
    .mem_data_ok(dok[0]), .mem_data_ready(mem_data_ready));

  ram_pipe #(.LATENCY(LAT1), .OUTSTANDING(OUT1), .FORCE_X2ZERO(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req(mem_req), .we(we), .addr(addr),
    .datai(datai), .wem(wem), .mem_addr_ok(aok[1]), .datao(dout[1]),
    .mem_data_ok(dok[1]), .mem_data_ready(mem_data_ready));

  // Model: per instance, a word array with known-byte masks and a queue of
  // pending responses (data, compare mask, first cycle it may be shown).
  int          lat_of [2] = '{LAT0, LAT1};
  int          out_of [2] = '{OUT0, OUT1};
  logic [31:0] mdata  [2][512];
  logic [3:0]  mknown [2][512];
  logic [31:0] qd [2][8];
  logic [31:0] qm [2][8];
  int          qt [2][8];
  int          qh [2];
  int          qn [2];
  int          cyc;
  bit          acc_c [2];
  bit          pop_c [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      qh[i] = 0;
      qn[i] = 0;
    end
  endtask

  task automatic model_compare();
    bit exp_ok, exp_aok;
    for (int i = 0; i < 2; i++) begin
      exp_ok  = (qn[i] > 0) && (qt[i][qh[i]] <= cyc);
      exp_aok = !rst && ((qn[i] < out_of[i]) || (exp_ok && mem_data_ready));
      check($sformatf("i%0d data_ok", i), 32'(dok[i]), 32'(exp_ok));
      check($sformatf("i%0d addr_ok", i), 32'(aok[i]), 32'(exp_aok));
      if (exp_ok)
        check($sformatf("i%0d datao", i), dout[i] & qm[i][qh[i]], qd[i][qh[i]] & qm[i][qh[i]]);
      acc_c[i] = mem_req && exp_aok;
      pop_c[i] = exp_ok && mem_data_ready;
    end
  endtask

  task automatic model_update();
    int idx, slot;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pop_c[i]) begin
        qh[i] = (qh[i] + 1) % 8;
        qn[i]--;
      end
      if (acc_c[i]) begin
        idx  = int'((addr >> 2) % 32'd512);
        slot = (qh[i] + qn[i]) % 8;
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (wem[b]) begin
              mdata[i][idx][8*b +: 8] = datai[8*b +: 8];
              mknown[i][idx][b] = 1'b1;
            end
          end
          qd[i][slot] = '0;
          qm[i][slot] = '1;
        end else begin
          qd[i][slot] = mdata[i][idx];
          qm[i][slot] = byte_mask(mknown[i][idx]);
        end
        qt[i][slot] = cyc + lat_of[i] - 1;
        qn[i]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic rdy);
    mem_req = r; we = w; addr = a; datai = d; wem = m; mem_data_ready = rdy;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 512; w++) begin
        mknown[i][w] = '0;
        mdata[i][w]  = '0;
      end
    model_reset();
    cyc = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset i%0d addr_ok", i), 32'(aok[i]), 32'd0);
      check($sformatf("reset i%0d data_ok", i), 32'(dok[i]), 32'd0);
      check($sformatf("reset i%0d datao", i), dout[i], 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full write then read back; write response carries zero.
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 32'h10, '0, '0, 1'b1);
    #1;
    check("t1 write resp valid", 32'(dok[0]), 32'd1);
    check("t1 write resp data", dout[0], 32'd0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    #1;
    check("t1 read valid", 32'(dok[0]), 32'd1);
    check("t1 read data", dout[0], 32'hDEADBEEF);
    idle(6);

    // Byte-masked overwrite.
    drive(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b1);
    cycle();
    drive(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 32'h20, '0, '0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    #1;
    check("t2 masked data", dout[0], 32'hFF22FF44);
    idle(6);

    // Back-to-back reads through the 3-cycle pipe.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 32'(4 * k), 32'h10000000 + 32'(k), 4'hF, 1'b1);
      cycle();
    end
    idle(6);
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1'b1, 1'b0, 32'(4 * k), '0, '0, 1'b1);
      else       drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      #1;
      if (k < 8) check($sformatf("t3 addr_ok k%0d", k), 32'(aok[1]), 32'd1);
      if (k == 1 || k == 2) check($sformatf("t3 early k%0d", k), 32'(dok[1]), 32'd0);
      if (k >= 3) begin
        check($sformatf("t3 valid k%0d", k), 32'(dok[1]), 32'd1);
        check($sformatf("t3 data k%0d", k), dout[1], 32'h10000000 + 32'(k - 3));
      end
      cycle();
    end
    idle(6);

    // Backpressure with two credits.
    for (int k = 0; k < 7; k++) begin
      if (k < 4)       drive(1'b1, 1'b0, 32'(4 * (1 + (k < 2 ? k : 2))), '0, '0, 1'b0);
      else if (k == 4) drive(1'b1, 1'b0, 32'hC, '0, '0, 1'b1);
      else             drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      #1;
      if (k == 2 || k == 3) begin
        check($sformatf("t4 full k%0d", k), 32'(aok[0]), 32'd0);
        check($sformatf("t4 hold k%0d", k), dout[0], 32'h10000001);
      end
      if (k == 4) begin
        check("t4 credit on pop", 32'(aok[0]), 32'd1);
        check("t4 head data", dout[0], 32'h10000001);
      end
      if (k == 5) check("t4 second", dout[0], 32'h10000002);
      if (k == 6) check("t4 third", dout[0], 32'h10000003);
      cycle();
    end
    idle(8);

    // Address wrap modulo DEPTH.
    drive(1'b1, 1'b1, 32'h800, 32'hA5A5A5A5, 4'hF, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 32'h000, '0, '0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    #1;
    check("t5 wrap data", dout[0], 32'hA5A5A5A5);
    idle(6);

    // Asynchronous reset with reads in flight.
    drive(1'b1, 1'b1, 32'h40, 32'h5A5A1234, 4'hF, 1'b1);
    cycle();
    idle(6);
    drive(1'b1, 1'b0, 32'h40, '0, '0, 1'b1);
    cycle();
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6 i%0d data_ok", i), 32'(dok[i]), 32'd0);
      check($sformatf("t6 i%0d addr_ok", i), 32'(aok[i]), 32'd0);
      check($sformatf("t6 i%0d datao", i), dout[i], 32'd0);
    end
    model_reset();
    #1;
    rst = 1'b0;
    idle(8);
    drive(1'b1, 1'b0, 32'h40, '0, '0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    #1;
    check("t6 write kept", dout[0], 32'h5A5A1234);
    idle(6);

    // Randomised traffic with random backpressure.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            ($urandom & 32'hFFFFF800) | (32'($urandom_range(0, 16)) << 2) | ($urandom & 32'h3),
            $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      cycle();
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
